stage2_conv_window: RTL and testbench
=====================================

# stage2_conv_window

Sliding-window generator for the stage-2 convolution. It consumes one channel of the 12x12 pooled feature map from `stage2_pooling` as a raster-order stream of 19-bit samples, one sample per `i_in_valid` cycle. It buffers the last four rows and emits every fully-populated 5x5 window (8x8 = 64 per frame) to the stage-2 conv MAC array. One instance is used per input channel (`ST2_Conv_CI` = 3).

## Interface
- `IBW`, default 19: sample bit width (`ST2_Conv_IBW`).
- `X`, default 12: frame width in samples (`ST2_Conv_X`).
- `Y`, default 12: frame height in samples (`ST2_Conv_Y`).
- `KX`, default 5: window width (`KX`).
- `KY`, default 5: window height (`KY`).
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_in_valid`  in  1  the sample on `i_in_fmap` is accepted this cycle. There is no ready signal; the block never stalls the producer.
- `i_in_fmap`  in  IBW  pooled sample, raster order (row-major, col 0 first).
- `o_ot_valid`  out  1  `o_ot_window` holds a complete window this cycle (1-cycle pulse per window).
- `o_ot_window`  out  KX*KY*IBW  window; element (ky,kx) at bits `[(ky*KX+kx)*IBW +: IBW]`. ky=0 is the top (oldest) row; kx=0 is the left (oldest) column.
- `o_ot_done`  out  1  pulses together with the last window of a frame.

## Operation
- Counters: `col` 0..X-1 and `row` 0..Y-1 track the position of the next accepted sample. On an accepted sample at `col`=X-1, `col` wraps to 0 and `row` increments. On an accepted sample at (Y-1, X-1), both wrap to 0 and the next frame starts immediately.
- Line buffers: KY-1 rows of X x IBW each, forming a shift chain. Each accepted sample is written at `col` into the newest line. The value previously held at that `col` moves down the chain to the next-older line.
- Window register: KY x KX x IBW. On each accepted sample, every window row shifts left by one. The new right column is loaded with the KY-1 buffered values at `col` (oldest at ky=0) plus the incoming sample at ky=KY-1.
- FSM states:
  - `S_FILL`: row < KY-1. Buffers are filling; no output. Goes to `S_RUN` on the accepted sample that completes row KY-2.
  - `S_RUN`: windows are emitted. Goes back to `S_FILL` on the accepted sample at (Y-1, X-1).
- Emission: in `S_RUN`, an accepted sample at `col` >= KX-1 produces a window. Output position is r = row-(KY-1), c = col-(KX-1), each in 0..7.
- Arithmetic: no arithmetic on samples. Values pass through bit-exact; no sign handling is required.
- Gaps: when `i_in_valid` is 0, counters, buffers, window and FSM all hold. `o_ot_valid` is 0.
- Reset (any time, including mid-frame): FSM goes to `S_FILL`, `row`/`col` to 0, `o_ot_valid`/`o_ot_done` to 0, `o_ot_window` to 0. Line-buffer contents are not cleared; stale data is never emitted because `S_FILL` rewrites every buffered row first. Reset has priority over `i_in_valid` in the same cycle.

## Timing
- Latency: `o_ot_valid` asserts exactly 1 cycle after the accepting edge of the sample that completes the window. `o_ot_window` is registered and stable for that cycle only.
- Throughput: one window per cycle; at most 64 windows per frame.
- `o_ot_done` is coincident with the 64th `o_ot_valid` of a frame.
- Back-to-back frames: a sample of frame N+1 may be accepted in the cycle right after the last sample of frame N. Frame N's last window still emits one cycle later.
- All outputs are 0 in the cycle after reset deasserts.

## Configuration
- `ST2_CONV_WIN_POS_EN` defined: adds output ports `o_ot_row` and `o_ot_col`, each 4 bits wide, registered alongside `o_ot_window`. They carry the window's output position (r, c), range 0..7, and reset to 0.
- Undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Ramp frame: `i_in_fmap`=i for i=0..143, continuous valid. Expect exactly 64 `o_ot_valid` pulses. The first comes 1 cycle after sample 52 is accepted, with element (ky,kx) = ky*12+kx, so (0,0)=0 and (4,4)=52.
- Same ramp, check every window: element (ky,kx) of window (r,c) = (r+ky)*12+(c+kx). The last window has (0,0)=91 and (4,4)=143, with `o_ot_done`=1.
- Random valid gaps (~50% duty) on the ramp: window contents and order identical to the continuous case. No `o_ot_valid` in any cycle not preceded by an accepted sample.
- Reset pulse after 30 samples, then a full ramp: the first window again follows the 53rd post-reset sample and equals the ramp values. No window is emitted from pre-reset data.
- Two back-to-back ramp frames, the second offset by +1000: 128 windows, 2 `o_ot_done` pulses. The second frame's first window has (0,0)=1000 and (4,4)=1052.
- With `ST2_CONV_WIN_POS_EN`: (r,c) sequences (0,0)..(0,7),(1,0)..(7,7), matching emission order.

Source files
------------

// File: rtl/stage2_conv_window_if.sv
// Sample-in / window-out bundle for stage2_conv_window; ST2_CONV_WIN_POS_EN adds o_ot_row/o_ot_col.
interface stage2_conv_window_if #(
  parameter int IBW = 19,
  parameter int KX  = 5,
  parameter int KY  = 5
);
  logic                  i_in_valid;
  logic [IBW-1:0]        i_in_fmap;
  logic                  o_ot_valid;
  logic [KX*KY*IBW-1:0]  o_ot_window;
  logic                  o_ot_done;
`ifdef ST2_CONV_WIN_POS_EN
  logic [3:0]            o_ot_row;
  logic [3:0]            o_ot_col;
`endif

  modport master (
`ifdef ST2_CONV_WIN_POS_EN
    input  o_ot_row, o_ot_col,
`endif
    output i_in_valid, i_in_fmap,
    input  o_ot_valid, o_ot_window, o_ot_done
  );

  modport slave (
`ifdef ST2_CONV_WIN_POS_EN
    output o_ot_row, o_ot_col,
`endif
    input  i_in_valid, i_in_fmap,
    output o_ot_valid, o_ot_window, o_ot_done
  );
endinterface

// File: rtl/stage2_conv_window.sv
// KXxKY sliding window over an XxY raster stream, 1-cycle latency, never stalls the producer (no ready).
// Optional macro ST2_CONV_WIN_POS_EN adds the registered window position outputs o_ot_row/o_ot_col.
module stage2_conv_window #(
  parameter int IBW = 19,
  parameter int X   = 12,
  parameter int Y   = 12,
  parameter int KX  = 5,
  parameter int KY  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  stage2_conv_window_if.slave  bus
);
  localparam int CW = $clog2(X);
  localparam int RW = $clog2(Y);
  localparam logic [CW-1:0] COL_LAST = CW'(X - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(Y - 1);
  localparam logic [CW-1:0] COL_OFF  = CW'(KX - 1);
  localparam logic [RW-1:0] ROW_OFF  = RW'(KY - 1);
  localparam logic [RW-1:0] ROW_FILL = RW'(KY - 2);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [IBW-1:0]        r_line [KY-1][X];
  logic [IBW-1:0]        r_win  [KY][KX];
  logic                  r_ot_valid;
  logic                  r_ot_done;
  logic                  w_acc;
  logic                  w_col_last;
  logic                  w_frame_last;
  logic                  w_emit;
  logic [KX*KY*IBW-1:0]  w_window;

  assign w_acc        = bus.i_in_valid;
  assign w_col_last   = (r_col == COL_LAST);
  assign w_frame_last = w_col_last && (r_row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    case (r_state)
      S_FILL: if (w_acc && w_col_last && (r_row == ROW_FILL)) w_state_nxt = S_RUN;
      S_RUN: begin
        w_emit = w_acc && (r_col >= COL_OFF);
        if (w_acc && w_frame_last) w_state_nxt = S_FILL;
      end
      default: w_state_nxt = S_FILL;
    endcase
  end

  // Line buffers are never cleared: the fill phase rewrites every row before it can reach a window.
  always_ff @(posedge clk) begin
    if (w_acc && !reset) begin
      for (int k = 0; k < KY - 2; k++) r_line[k][r_col] <= r_line[k+1][r_col];
      r_line[KY-2][r_col] <= bus.i_in_fmap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++) r_win[ky][kx] <= '0;
    end else if (w_acc) begin
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX - 1; kx++) r_win[ky][kx] <= r_win[ky][kx+1];
      for (int ky = 0; ky < KY - 1; ky++) r_win[ky][KX-1] <= r_line[ky][r_col];
      r_win[KY-1][KX-1] <= bus.i_in_fmap;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ot_valid <= 1'b0;
      r_ot_done  <= 1'b0;
    end else begin
      r_ot_valid <= w_emit;
      r_ot_done  <= w_emit && w_frame_last;
    end
  end

`ifdef ST2_CONV_WIN_POS_EN
  logic [3:0] r_ot_row;
  logic [3:0] r_ot_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ot_row <= '0;
      r_ot_col <= '0;
    end else if (w_emit) begin
      r_ot_row <= 4'(r_row - ROW_OFF);
      r_ot_col <= 4'(r_col - COL_OFF);
    end
  end

  assign bus.o_ot_row = r_ot_row;
  assign bus.o_ot_col = r_ot_col;
`endif

  always_comb begin
    w_window = '0;
    for (int ky = 0; ky < KY; ky++)
      for (int kx = 0; kx < KX; kx++) w_window[(ky*KX+kx)*IBW +: IBW] = r_win[ky][kx];
  end

  assign bus.o_ot_valid  = r_ot_valid;
  assign bus.o_ot_done   = r_ot_done;
  assign bus.o_ot_window = w_window;
endmodule

// File: tb/tb_stage2_conv_window.sv
// Randomized bench for stage2_conv_window against a frame-array reference model.
module tb_stage2_conv_window;
  localparam int IBW = 19;
  localparam int X   = 12;
  localparam int Y   = 12;
  localparam int KX  = 5;
  localparam int KY  = 5;
  localparam int W   = KX * KY * IBW;

  logic clk = 1'b0;
  logic reset;

  stage2_conv_window_if #(.IBW(IBW), .KX(KX), .KY(KY)) bus ();

  stage2_conv_window #(.IBW(IBW), .X(X), .Y(Y), .KX(KX), .KY(KY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int             frame [Y][X];
  int             mrow, mcol;
  logic           exp_valid, exp_done;
  logic [W-1:0]   exp_win;
  int             exp_r, exp_c;

  int             n_win, n_done, acc_cnt, first_at;
  logic [W-1:0]   first_win, last_win, win65;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int elem(input logic [W-1:0] w, input int ky, input int kx);
    return int'(w[(ky*KX+kx)*IBW +: IBW]);
  endfunction

  task automatic clear_stats();
    n_win = 0; n_done = 0; acc_cnt = 0; first_at = -1;
    first_win = '0; last_win = '0; win65 = '0;
  endtask

  // One clock: drive inputs, advance the model, check outputs on the falling edge.
  task automatic step(input logic v, input logic [IBW-1:0] d, input logic rst);
    reset = rst;
    bus.i_in_valid = v;
    bus.i_in_fmap  = d;
    if (rst) begin
      mrow = 0; mcol = 0;
      exp_valid = 1'b0; exp_done = 1'b0; exp_win = '0; exp_r = 0; exp_c = 0;
    end else if (v) begin
      acc_cnt++;
      frame[mrow][mcol] = int'(d);
      exp_done = 1'b0;
      if (mrow >= KY - 1 && mcol >= KX - 1) begin
        exp_valid = 1'b1;
        exp_r = mrow - (KY - 1);
        exp_c = mcol - (KX - 1);
        for (int ky = 0; ky < KY; ky++)
          for (int kx = 0; kx < KX; kx++)
            exp_win[(ky*KX+kx)*IBW +: IBW] = IBW'(frame[exp_r+ky][exp_c+kx]);
        exp_done = (mrow == Y - 1) && (mcol == X - 1);
      end else begin
        exp_valid = 1'b0;
      end
      if (mcol == X - 1) begin
        mcol = 0;
        mrow = (mrow == Y - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end else begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check("valid", W'(bus.o_ot_valid), W'(exp_valid));
    check("done", W'(bus.o_ot_done), W'(exp_done));
    if (rst) begin
      check("rst_window", bus.o_ot_window, '0);
`ifdef ST2_CONV_WIN_POS_EN
      check("rst_row", W'(bus.o_ot_row), '0);
      check("rst_col", W'(bus.o_ot_col), '0);
`endif
    end
    if (bus.o_ot_valid && exp_valid) begin
      check("window", bus.o_ot_window, exp_win);
`ifdef ST2_CONV_WIN_POS_EN
      check("pos_row", W'(bus.o_ot_row), W'(exp_r));
      check("pos_col", W'(bus.o_ot_col), W'(exp_c));
`endif
      n_win++;
      if (n_win == 1) begin
        first_win = bus.o_ot_window;
        first_at  = acc_cnt;
      end
      if (n_win == 65) win65 = bus.o_ot_window;
      last_win = bus.o_ot_window;
    end
    if (bus.o_ot_done) n_done++;
  endtask

  task automatic ramp(input int base, input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps) while ($urandom_range(1) == 0) step(1'b0, IBW'($urandom), 1'b0);
      step(1'b1, IBW'(base + i), 1'b0);
    end
  endtask

  task automatic check_ramp_frame(input string tag);
    check({tag, "_nwin"}, W'(n_win), W'(64));
    check({tag, "_ndone"}, W'(n_done), W'(1));
    check({tag, "_first_at"}, W'(first_at), W'(53));
    check({tag, "_first00"}, W'(elem(first_win, 0, 0)), W'(0));
    check({tag, "_first01"}, W'(elem(first_win, 0, 1)), W'(1));
    check({tag, "_first10"}, W'(elem(first_win, 1, 0)), W'(12));
    check({tag, "_first44"}, W'(elem(first_win, 4, 4)), W'(52));
    check({tag, "_last00"}, W'(elem(last_win, 0, 0)), W'(91));
    check({tag, "_last44"}, W'(elem(last_win, 4, 4)), W'(143));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.i_in_valid = 1'b0;
    bus.i_in_fmap  = '0;
    clear_stats();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);

    clear_stats();
    ramp(0, X * Y, 1'b0);
    check_ramp_frame("cont");

    clear_stats();
    ramp(0, X * Y, 1'b1);
    check_ramp_frame("gaps");

    ramp(5000, 30, 1'b0);
    step(1'b1, IBW'(777), 1'b1);
    step(1'b0, '0, 1'b1);
    clear_stats();
    ramp(0, X * Y, 1'b0);
    check_ramp_frame("midrst");

    clear_stats();
    ramp(0, X * Y, 1'b0);
    ramp(1000, X * Y, 1'b0);
    check("b2b_nwin", W'(n_win), W'(128));
    check("b2b_ndone", W'(n_done), W'(2));
    check("b2b_f2_00", W'(elem(win65, 0, 0)), W'(1000));
    check("b2b_f2_44", W'(elem(win65, 4, 4)), W'(1052));
    check("b2b_last44", W'(elem(last_win, 4, 4)), W'(1143));

    for (int i = 0; i < 3; i++) step(1'b0, IBW'($urandom), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
